// File: rtl/eq_pkg.sv
// eq_pkg: shared types and helpers for the n-band equaliser.
//   eq_state_e      - sequencing states of the equaliser datapath
//   gain_from_level - level code -> Q(FRAC_W) gain, 0.25 steps, level 3 = unity
//   acc_width       - width of the MAC accumulator
//   nbands_legal    - legal range check for the band count
package eq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_MAC   = 2'd2,
        ST_SAT   = 2'd3
    } eq_state_e;

    function automatic int gain_from_level(input int level, input int frac_w);
        return (level + 1) << (frac_w - 2);
    endfunction

    // band (DATA_W+1) x gain (GAIN_W), plus headroom for NUM_BANDS terms
    function automatic int acc_width(input int data_w, input int gain_w, input int num_bands);
        return data_w + 1 + gain_w + $clog2(num_bands);
    endfunction

    function automatic bit nbands_legal(input int num_bands);
        return (num_bands >= 2) && (num_bands <= 8);
    endfunction

endpackage

// File: rtl/eq_gain_ramp.sv
// eq_gain_ramp: current-gain register of one band.
//   i_clk, i_rst_n - clock, asynchronous active-low reset (gain -> unity)
//   i_step         - one ramp step toward i_target this cycle
//   i_target       - signed Q(FRAC_W) target gain
//   o_gain         - signed Q(FRAC_W) current gain
// The gain moves by RAMP_STEP LSBs per step and lands exactly on the target
// (never overshoots). RAMP_STEP = 0 jumps straight to the target.
module eq_gain_ramp #(
    parameter int GAIN_W    = 9,
    parameter int FRAC_W    = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_step,
    input  logic signed [GAIN_W-1:0] i_target,
    output logic signed [GAIN_W-1:0] o_gain
);

    localparam logic signed [GAIN_W:0] STEP = (GAIN_W + 1)'(RAMP_STEP);

    // one extra bit so the difference of two GAIN_W values cannot wrap
    logic signed [GAIN_W:0] diff;

    always_comb begin
        diff = {i_target[GAIN_W-1], i_target} - {o_gain[GAIN_W-1], o_gain};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_gain <= GAIN_W'(1 << FRAC_W);
        end else if (i_step) begin
            if ((RAMP_STEP == 0) || ((diff <= STEP) && (diff >= -STEP))) begin
                o_gain <= i_target;
            end else if (diff > 0) begin
                o_gain <= o_gain + GAIN_W'(RAMP_STEP);
            end else begin
                o_gain <= o_gain - GAIN_W'(RAMP_STEP);
            end
        end
    end

endmodule

// File: rtl/effect_eq_nband.sv
// effect_eq_nband: NUM_BANDS-band graphic equaliser, one sample in flight.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_valid/o_ready - input handshake; a sample is accepted on a rising edge
//                     where both are high. o_ready is high only when idle and
//                     i_valid while busy is dropped, never queued.
//   i_enable       - 1 equalise, 0 bypass (captured with the sample)
//   i_level        - per-band level codes, band b at [b*LEVEL_W +: LEVEL_W]
//   i_data         - signed input sample
//   o_data/o_valid - result, held; o_valid pulses one cycle per sample,
//                    NUM_BANDS+2 cycles after the accept edge
//   o_dbg_state    - current sequencing state (eq_state_e encoding)
// Flow: IDLE -> SPLIT (crossover filters and gain ramps step) -> MAC
// (NUM_BANDS cycles on one shared multiplier) -> SAT (shift, clamp) -> IDLE.
module effect_eq_nband
    import eq_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_BANDS = 4,
    parameter int LEVEL_W   = 3,
    parameter int FRAC_W    = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic                           i_enable,
    input  logic [NUM_BANDS*LEVEL_W-1:0]   i_level,
    input  logic signed [DATA_W-1:0]       i_data,
    output logic signed [DATA_W-1:0]       o_data,
    output logic                           o_valid,
    output logic [1:0]                     o_dbg_state
);

    localparam int GAIN_W = FRAC_W + 5;
    localparam int PROD_W = DATA_W + 1 + GAIN_W;
    localparam int ACC_W  = acc_width(DATA_W, GAIN_W, NUM_BANDS);
    localparam int IDX_W  = $clog2(NUM_BANDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    if (!nbands_legal(NUM_BANDS)) begin : g_bad_nbands
        $error("effect_eq_nband: NUM_BANDS must be in 2..8");
    end

    eq_state_e state, state_n;

    logic signed [DATA_W-1:0]     x_q;
    logic                         en_q;
    logic [NUM_BANDS*LEVEL_W-1:0] level_q;
    logic signed [DATA_W-1:0]     lp_q [NUM_BANDS-1];
    logic signed [DATA_W:0]       band [NUM_BANDS];
    logic signed [GAIN_W-1:0]     cur_gain [NUM_BANDS];
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      acc_shr;
    logic [IDX_W-1:0]             idx_q;
    logic signed [PROD_W-1:0]     prod;
    logic signed [DATA_W-1:0]     sat_val;
    logic                         accept;

    function automatic logic signed [DATA_W:0] sx(input logic signed [DATA_W-1:0] v);
        return {v[DATA_W-1], v};
    endfunction

    // lp += (x - lp) >>> sh; lp stays between its old value and x, so the
    // sum always fits back into DATA_W bits
    function automatic logic signed [DATA_W-1:0] lp_step(
        input logic signed [DATA_W-1:0] lp,
        input logic signed [DATA_W-1:0] x,
        input int                       sh
    );
        logic signed [DATA_W:0] d;
        d = sx(x) - sx(lp);
        return DATA_W'(sx(lp) + (d >>> sh));
    endfunction

    assign o_ready     = (state == ST_IDLE);
    assign accept      = i_valid && o_ready;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (i_valid) state_n = ST_SPLIT;
            ST_SPLIT: state_n = ST_MAC;
            ST_MAC:   if (idx_q == LAST_IDX) state_n = ST_SAT;
            ST_SAT:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Bands telescope, so their sum is x exactly.
    always_comb begin
        band[0] = sx(lp_q[0]);
        for (int k = 1; k < NUM_BANDS - 1; k++) begin
            band[k] = sx(lp_q[k]) - sx(lp_q[k-1]);
        end
        band[NUM_BANDS-1] = sx(x_q) - sx(lp_q[NUM_BANDS-2]);
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        logic [LEVEL_W-1:0]       lvl;
        logic signed [GAIN_W-1:0] target;

        assign lvl    = level_q[b*LEVEL_W +: LEVEL_W];
        assign target = GAIN_W'(gain_from_level(int'(lvl), FRAC_W));

        eq_gain_ramp #(
            .GAIN_W    (GAIN_W),
            .FRAC_W    (FRAC_W),
            .RAMP_STEP (RAMP_STEP)
        ) u_ramp (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_step   (state == ST_SPLIT),
            .i_target (target),
            .o_gain   (cur_gain[b])
        );
    end

    always_comb begin
        prod    = band[idx_q] * cur_gain[idx_q];
        acc_shr = acc_q >>> FRAC_W;
        if (acc_shr > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (acc_shr < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_val = acc_shr[DATA_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q     <= '0;
            en_q    <= 1'b0;
            level_q <= '0;
            for (int k = 0; k < NUM_BANDS - 1; k++) begin
                lp_q[k] <= '0;
            end
            acc_q   <= '0;
            idx_q   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (accept) begin
                x_q     <= i_data;
                en_q    <= i_enable;
                level_q <= i_level;
            end
            case (state)
                ST_SPLIT: begin
                    for (int k = 0; k < NUM_BANDS - 1; k++) begin
                        lp_q[k] <= lp_step(lp_q[k], x_q, 2 * (NUM_BANDS - 1 - k));
                    end
                    acc_q <= '0;
                    idx_q <= '0;
                end
                ST_MAC: begin
                    acc_q <= acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                    idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end
                ST_SAT: begin
                    o_valid <= 1'b1;
                    o_data  <= en_q ? sat_val : x_q;
                end
                default: ;
            endcase
        end
    end

endmodule
